// File: rtl/rgb_gray_pkg.sv
// Shared definitions for the RGB-to-gray host: FSM encoding, pixel channel
// positions and the converter's fixed latency.
package rgb_gray_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam int R_MSB = 23;
  localparam int G_MSB = 15;
  localparam int B_MSB = 7;

  // Cycles from converter input_valid to its output_valid pulse
  localparam int CV_LAT = 5;

endpackage

// File: rtl/gray_out_fifo.sv
// Small synchronous FIFO holding {last, gray} results; head is presented from
// registers, and a read and a write in the same cycle are allowed even when full.
module gray_out_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign do_rd   = rd_en && (count != '0);
  assign do_wr   = wr_en && ((count < CW'(DEPTH)) || do_rd);
  // Head is forced to zero when empty so stale entries never leak out after reset
  assign rd_data = (count != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (do_wr && !do_rd) begin
        count <= count + CW'(1);
      end else if (!do_wr && do_rd) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/rgb_to_gray_host.sv
// Drives one pixel at a time into the multi-cycle RGB-to-gray converter and
// queues results on an output stream, with a watchdog on converter replies.
module rgb_to_gray_host
  import rgb_gray_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [23:0]      s_rgb,
  input  logic             s_last,
  output logic             cv_valid,
  output logic [7:0]       cv_r,
  output logic [7:0]       cv_g,
  output logic [7:0]       cv_b,
  input  logic             cv_done,
  input  logic [7:0]       cv_gray,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [7:0]       m_gray,
  output logic             m_last,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] pix_cnt
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t              state;
  state_t              state_nxt;
  logic [23:0]         hold_rgb;
  logic                hold_last;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [FCNT_W-1:0]   fifo_cnt;
  logic [8:0]          fifo_dout;
  logic                accept;
  logic                fifo_wr;
  logic                fifo_rd;
  logic                timeout;

  // Accepting only in IDLE with room left means the WAIT write can never overflow
  assign s_ready  = (state == IDLE) && (fifo_cnt < FCNT_W'(FIFO_DEPTH));
  assign accept   = s_valid && s_ready;
  assign cv_valid = (state == ISSUE);
  assign cv_r     = hold_rgb[R_MSB -: 8];
  assign cv_g     = hold_rgb[G_MSB -: 8];
  assign cv_b     = hold_rgb[B_MSB -: 8];
  assign fifo_wr  = (state == WAIT) && cv_done;
  assign timeout  = (state == WAIT) && !cv_done && (wait_cnt == WAIT_W'(TIMEOUT - 1));
  assign fifo_rd  = m_valid && m_ready;
  assign m_valid  = (fifo_cnt != '0);
  assign m_last   = fifo_dout[8];
  assign m_gray   = fifo_dout[7:0];
  assign busy     = (state != IDLE) || m_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cv_done || timeout) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_rgb  <= '0;
      hold_last <= 1'b0;
    end else if (accept) begin
      hold_rgb  <= s_rgb;
      hold_last <= s_last;
    end
  end

  // Counter restarts on ISSUE so the watchdog measures only time spent in WAIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == ISSUE) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt <= '0;
      err     <= 1'b0;
    end else begin
      if (fifo_wr) begin
        pix_cnt <= pix_cnt + CNT_W'(1);
      end
      if (timeout) begin
        err <= 1'b1;
      end
    end
  end

  gray_out_fifo #(
    .WIDTH (9),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data ({hold_last, cv_gray}),
    .rd_en   (fifo_rd),
    .rd_data (fifo_dout),
    .count   (fifo_cnt)
  );

endmodule

// File: tb/tb_rgb_to_gray_host.sv
// Directed bench for rgb_to_gray_host with a behavioural converter model;
// also exercises the output FIFO on its own for the full read-plus-write case.
module tb_rgb_to_gray_host;
  import rgb_gray_pkg::*;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] s_rgb;
  logic        s_last;
  logic        cv_valid;
  logic [7:0]  cv_r;
  logic [7:0]  cv_g;
  logic [7:0]  cv_b;
  logic        cv_done;
  logic [7:0]  cv_gray;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_gray;
  logic        m_last;
  logic        busy;
  logic        err;
  logic [15:0] pix_cnt;

  logic        f_wr_en;
  logic [8:0]  f_wr_data;
  logic        f_rd_en;
  logic [8:0]  f_rd_data;
  logic [2:0]  f_count;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [23:0] pix_rgb [16];
  logic        pix_last [16];
  int          acc [16];
  logic [8:0]  outq [$];

  logic        model_done;
  logic [7:0]  model_gray;
  logic [7:0]  cv_latched;
  int          cv_timer;
  logic        cv_hang;
  logic        stray_done;
  logic [7:0]  stray_gray;

  rgb_to_gray_host #(
    .FIFO_DEPTH (4),
    .TIMEOUT    (15),
    .CNT_W      (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_rgb    (s_rgb),
    .s_last   (s_last),
    .cv_valid (cv_valid),
    .cv_r     (cv_r),
    .cv_g     (cv_g),
    .cv_b     (cv_b),
    .cv_done  (cv_done),
    .cv_gray  (cv_gray),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_gray   (m_gray),
    .m_last   (m_last),
    .busy     (busy),
    .err      (err),
    .pix_cnt  (pix_cnt)
  );

  gray_out_fifo #(
    .WIDTH (9),
    .DEPTH (4)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (f_wr_en),
    .wr_data (f_wr_data),
    .rd_en   (f_rd_en),
    .rd_data (f_rd_data),
    .count   (f_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in converter: result is a fixed checksum of the channels, returned CV_LAT cycles later
  function automatic logic [7:0] exp_gray(input logic [23:0] rgb);
    return rgb[23:16] ^ rgb[15:8] ^ rgb[7:0] ^ 8'hE9;
  endfunction

  always @(posedge clk) begin
    model_done <= 1'b0;
    if (cv_valid) begin
      cv_timer   <= 1;
      cv_latched <= exp_gray({cv_r, cv_g, cv_b});
    end else if (cv_timer != 0) begin
      if (cv_timer == CV_LAT - 1) begin
        cv_timer   <= 0;
        model_done <= !cv_hang;
        model_gray <= cv_latched;
      end else begin
        cv_timer <= cv_timer + 1;
      end
    end
  end

  assign cv_done = model_done | stray_done;
  assign cv_gray = stray_done ? stray_gray : model_gray;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyReset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Offers one pixel; returns at the negedge of the ISSUE cycle with the accept cycle number
  task automatic applyStimulus(input logic [23:0] rgb, input logic last, output int acc_cyc);
    acc_cyc = -1;
    s_rgb   = rgb;
    s_last  = last;
    s_valid = 1'b1;
    for (int i = 0; i < 40 && acc_cyc < 0; i++) begin
      if (s_ready) acc_cyc = cyc;
      @(negedge clk);
    end
    s_valid = 1'b0;
    if (acc_cyc < 0) checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic streamPixels(input int first, input int n, input int budget);
    int k;
    bit pend;
    k       = first;
    pend    = 1'b0;
    s_rgb   = pix_rgb[k];
    s_last  = pix_last[k];
    s_valid = 1'b1;
    for (int t = 0; t < budget; t++) begin
      if (pend) begin
        pend = 1'b0;
        k++;
        if (k < first + n) begin
          s_rgb  = pix_rgb[k];
          s_last = pix_last[k];
        end else begin
          s_valid = 1'b0;
        end
      end
      if (m_valid && m_ready) outq.push_back({m_last, m_gray});
      if (s_valid && s_ready) begin
        acc[k] = cyc;
        pend   = 1'b1;
      end
      if (k == first + n && !busy) break;
      @(negedge clk);
    end
    if (pend) k++;
    s_valid = 1'b0;
    checkOutput("stream_accepts", k - first, n);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL global_timeout: time limit reached before completion");
    $fatal(1);
  end

  initial begin
    int a;
    int b;
    int r;
    logic [8:0] drain_exp [4];

    rst = 1'b1; s_valid = 1'b0; s_rgb = '0; s_last = 1'b0; m_ready = 1'b0;
    cv_hang = 1'b0; stray_done = 1'b0; stray_gray = '0;
    f_wr_en = 1'b0; f_rd_en = 1'b0; f_wr_data = '0;
    cv_timer = 0; model_done = 1'b0; model_gray = '0; cv_latched = '0;

    #12;
    $display("[TB] reset state");
    checkOutput("rst_s_ready", 32'(s_ready), 1);
    checkOutput("rst_m_valid", 32'(m_valid), 0);
    checkOutput("rst_cv_valid", 32'(cv_valid), 0);
    checkOutput("rst_cv_rgb", 32'({cv_r, cv_g, cv_b}), 0);
    checkOutput("rst_pix_cnt", 32'(pix_cnt), 0);
    checkOutput("rst_err", 32'(err), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] single pixel");
    applyStimulus(24'hFF8000, 1'b1, a);
    checkOutput("t1_cv_valid", 32'(cv_valid), 1);
    checkOutput("t1_cv_r", 32'(cv_r), 'hFF);
    checkOutput("t1_cv_g", 32'(cv_g), 'h80);
    checkOutput("t1_cv_b", 32'(cv_b), 'h00);
    @(negedge clk);
    checkOutput("t1_cv_valid_pulse", 32'(cv_valid), 0);
    checkOutput("t1_cv_r_held", 32'(cv_r), 'hFF);
    waitUntil(a + 6);
    checkOutput("t1_m_valid_early", 32'(m_valid), 0);
    waitUntil(a + 7);
    checkOutput("t1_m_valid", 32'(m_valid), 1);
    checkOutput("t1_m_gray", 32'(m_gray), 'h96);
    checkOutput("t1_m_last", 32'(m_last), 1);
    checkOutput("t1_pix_cnt", 32'(pix_cnt), 1);
    checkOutput("t1_busy_fifo", 32'(busy), 1);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    checkOutput("t1_popped", 32'(m_valid), 0);
    checkOutput("t1_idle", 32'(busy), 0);

    $display("[TB] ten back-to-back pixels");
    applyReset();
    for (int i = 0; i < 10; i++) begin
      pix_rgb[i]  = {8'(i * 23 + 5), 8'(200 - i * 11), 8'(i * 7)};
      pix_last[i] = (i == 9);
    end
    outq.delete();
    m_ready = 1'b1;
    streamPixels(0, 10, 120);
    for (int i = 1; i < 10; i++) checkOutput($sformatf("t2_spacing_%0d", i), acc[i] - acc[i-1], 7);
    checkOutput("t2_out_count", outq.size(), 10);
    for (int i = 0; i < 10 && i < outq.size(); i++)
      checkOutput($sformatf("t2_out_%0d", i), 32'(outq[i]), 32'({pix_last[i], exp_gray(pix_rgb[i])}));
    checkOutput("t2_pix_cnt", 32'(pix_cnt), 10);

    $display("[TB] backpressure with full FIFO");
    applyReset();
    for (int i = 0; i < 6; i++) begin
      pix_rgb[i]  = {8'(i * 40), 8'(i * 3 + 1), 8'(255 - i * 30)};
      pix_last[i] = (i == 5);
    end
    outq.delete();
    m_ready = 1'b0;
    streamPixels(0, 4, 36);
    checkOutput("t3_pix_cnt_full", 32'(pix_cnt), 4);
    checkOutput("t3_m_valid_full", 32'(m_valid), 1);
    checkOutput("t3_s_ready_full", 32'(s_ready), 0);
    checkOutput("t3_no_pops", outq.size(), 0);
    r = cyc;
    m_ready = 1'b1;
    streamPixels(4, 2, 60);
    checkOutput("t3_accept_after_read", acc[4], r + 1);
    checkOutput("t3_spacing_5", acc[5] - acc[4], 7);
    checkOutput("t3_out_count", outq.size(), 6);
    for (int i = 0; i < 6 && i < outq.size(); i++)
      checkOutput($sformatf("t3_out_%0d", i), 32'(outq[i]), 32'({pix_last[i], exp_gray(pix_rgb[i])}));
    checkOutput("t3_pix_cnt", 32'(pix_cnt), 6);

    $display("[TB] converter hang");
    applyReset();
    m_ready = 1'b0;
    cv_hang = 1'b1;
    applyStimulus(24'h123456, 1'b0, a);
    waitUntil(a + 16);
    checkOutput("t4_err_before", 32'(err), 0);
    checkOutput("t4_busy_before", 32'(busy), 1);
    waitUntil(a + 17);
    checkOutput("t4_err", 32'(err), 1);
    checkOutput("t4_idle", 32'(busy), 0);
    checkOutput("t4_s_ready", 32'(s_ready), 1);
    checkOutput("t4_no_write", 32'(m_valid), 0);
    checkOutput("t4_pix_cnt", 32'(pix_cnt), 0);
    cv_hang = 1'b0;
    stray_gray = 8'h55;
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    @(negedge clk);
    checkOutput("t4_stray_pix_cnt", 32'(pix_cnt), 0);
    checkOutput("t4_stray_m_valid", 32'(m_valid), 0);
    checkOutput("t4_err_sticky", 32'(err), 1);

    $display("[TB] reset during WAIT");
    applyReset();
    for (int i = 0; i < 2; i++) begin
      pix_rgb[i]  = {8'(i + 1), 8'(i + 2), 8'(i + 3)};
      pix_last[i] = 1'b0;
    end
    outq.delete();
    m_ready = 1'b0;
    streamPixels(0, 2, 24);
    checkOutput("t5_pix_cnt_pre", 32'(pix_cnt), 2);
    applyStimulus(24'hABCDEF, 1'b1, a);
    repeat (2) @(negedge clk);
    checkOutput("t5_busy_wait", 32'(busy), 1);
    #1 rst = 1'b1;
    #1;
    checkOutput("t5_m_valid", 32'(m_valid), 0);
    checkOutput("t5_pix_cnt", 32'(pix_cnt), 0);
    checkOutput("t5_s_ready", 32'(s_ready), 1);
    checkOutput("t5_busy", 32'(busy), 0);
    checkOutput("t5_cv_rgb", 32'({cv_r, cv_g, cv_b}), 0);
    @(negedge clk);
    rst = 1'b0;
    waitUntil(a + 10);
    checkOutput("t5_stray_ignored", 32'(pix_cnt), 0);
    checkOutput("t5_stray_no_write", 32'(m_valid), 0);
    m_ready = 1'b1;
    applyStimulus(24'h00FF00, 1'b1, b);
    m_ready = 1'b0;
    waitUntil(b + 7);
    checkOutput("t5_next_m_valid", 32'(m_valid), 1);
    checkOutput("t5_next_m_gray", 32'(m_gray), 'h16);
    checkOutput("t5_next_m_last", 32'(m_last), 1);
    checkOutput("t5_next_pix_cnt", 32'(pix_cnt), 1);

    $display("[TB] FIFO full with simultaneous read and write");
    applyReset();
    f_wr_en = 1'b1;
    f_wr_data = 9'h101; @(negedge clk);
    f_wr_data = 9'h102; @(negedge clk);
    f_wr_en = 1'b0;
    f_rd_en = 1'b1;
    checkOutput("t6_pre_head0", 32'(f_rd_data), 'h101);
    @(negedge clk);
    checkOutput("t6_pre_head1", 32'(f_rd_data), 'h102);
    @(negedge clk);
    f_rd_en = 1'b0;
    checkOutput("t6_empty", 32'(f_count), 0);
    f_wr_en = 1'b1;
    for (int j = 0; j < 4; j++) begin
      f_wr_data = 9'(9'h1A0 + j);
      @(negedge clk);
    end
    checkOutput("t6_full", 32'(f_count), 4);
    f_rd_en = 1'b1;
    for (int j = 0; j < 3; j++) begin
      f_wr_data = 9'(9'h0B0 + j);
      checkOutput($sformatf("t6_rw_head_%0d", j), 32'(f_rd_data), 32'(9'h1A0 + j));
      @(negedge clk);
      checkOutput($sformatf("t6_rw_count_%0d", j), 32'(f_count), 4);
    end
    f_wr_en = 1'b0;
    drain_exp = '{9'h1A3, 9'h0B0, 9'h0B1, 9'h0B2};
    for (int j = 0; j < 4; j++) begin
      checkOutput($sformatf("t6_drain_%0d", j), 32'(f_rd_data), 32'(drain_exp[j]));
      @(negedge clk);
    end
    f_rd_en = 1'b0;
    checkOutput("t6_drained", 32'(f_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
